// File: rtl/database_tx_serializer_pkg.sv
// rtl/database_tx_serializer_pkg.sv - shared types and defaults for the debug dump serializer
package database_tx_serializer_pkg;

  localparam int unsigned DEF_LONGITUD_INSTRUCCION       = 32;
  localparam int unsigned DEF_OUTPUT_WORD_LENGTH         = 8;
  localparam int unsigned DEF_CANT_BITS_CONTROL_DATABASE = 3;
  localparam int unsigned DEF_CANT_DATOS                 = 4;
  localparam int unsigned BYTES_PER_WORD = DEF_LONGITUD_INSTRUCCION / DEF_OUTPUT_WORD_LENGTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_FIN    = 3'd6
  } ser_state_t;

  // Word order of a dump as seen by the PC side
  typedef enum logic [1:0] {
    DB_PC          = 2'd0,
    DB_CICLOS      = 2'd1,
    DB_PC_PLUS4    = 2'd2,
    DB_INSTR_FETCH = 2'd3
  } db_index_t;

  // A one-byte word still needs a 1-bit counter
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/database_tx_serializer.sv
// rtl/database_tx_serializer.sv - walks the database words and sends each one MSB-first over UART tx
module database_tx_serializer
  import database_tx_serializer_pkg::*;
#(
  parameter int unsigned LONGITUD_INSTRUCCION       = DEF_LONGITUD_INSTRUCCION,
  parameter int unsigned OUTPUT_WORD_LENGTH         = DEF_OUTPUT_WORD_LENGTH,
  parameter int unsigned CANT_BITS_CONTROL_DATABASE = DEF_CANT_BITS_CONTROL_DATABASE,
  parameter int unsigned CANT_DATOS                 = DEF_CANT_DATOS
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic [LONGITUD_INSTRUCCION-1:0]       i_dato_database,
  input  logic                                  i_tx_done,
  output logic [CANT_BITS_CONTROL_DATABASE-1:0] o_control_database,
  output logic                                  o_tx_start,
  output logic [OUTPUT_WORD_LENGTH-1:0]         o_data_tx,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int unsigned BYTES = LONGITUD_INSTRUCCION / OUTPUT_WORD_LENGTH;
  localparam int unsigned BCW   = cnt_width(BYTES);
  localparam int unsigned IW    = CANT_BITS_CONTROL_DATABASE;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(CANT_DATOS - 1);

  ser_state_t                      state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [BCW-1:0]                  byte_cnt_q, byte_cnt_d;
  logic [LONGITUD_INSTRUCCION-1:0] shreg_q, shreg_d;
  logic                            busy_q, busy_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    o_tx_start = 1'b0;
    o_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SELECT;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end

      // Database answers one cycle after the select moves
      ST_SELECT: state_d = ST_LOAD;

      ST_LOAD: begin
        shreg_d    = i_dato_database;
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        o_tx_start = 1'b1;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_tx_done) begin
          shreg_d    = shreg_q << OUTPUT_WORD_LENGTH;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          state_d    = (byte_cnt_q == LAST_BYTE) ? ST_NEXT : ST_SEND;
        end
      end

      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SELECT;
        end
      end

      // A start arriving here is dropped: the dump is not re-armed
      ST_FIN: begin
        o_done  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The top of the shift register is the byte in flight; held until the tx acknowledges
  assign o_data_tx          = shreg_q[LONGITUD_INSTRUCCION-1 -: OUTPUT_WORD_LENGTH];
  assign o_control_database = idx_q;
  assign o_busy             = busy_q;

endmodule

// File: tb/tb_database_tx_serializer.sv
// tb/tb_database_tx_serializer.sv - scoreboard bench for database_tx_serializer
module tb_database_tx_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, done_in_a = 1'b0;
  logic [31:0] dato_a;
  logic [2:0]  sel_a;
  logic        tx_start_a, busy_a, done_a;
  logic [7:0]  data_a;

  logic        start_b = 1'b0, done_in_b = 1'b0;
  logic [31:0] dato_b;
  logic [2:0]  sel_b;
  logic        tx_start_b, busy_b, done_b;
  logic [7:0]  data_b;

  database_tx_serializer #(.CANT_DATOS(4)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_dato_database(dato_a),
    .i_tx_done(done_in_a), .o_control_database(sel_a), .o_tx_start(tx_start_a),
    .o_data_tx(data_a), .o_busy(busy_a), .o_done(done_a)
  );

  database_tx_serializer #(.CANT_DATOS(1)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_dato_database(dato_b),
    .i_tx_done(done_in_b), .o_control_database(sel_b), .o_tx_start(tx_start_b),
    .o_data_tx(data_b), .o_busy(busy_b), .o_done(done_b)
  );

  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];
  always @(posedge clk) begin
    dato_a <= mem_a[sel_a];
    dato_b <= mem_b[sel_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         sel;
    logic [7:0] data;
    bit         from_start;
    int         lat;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int tests = 0, fails = 0;
  int start_cyc = 0, done_cyc = 0;
  int bytes_a = 0, dones_a = 0, dones_b = 0;
  int tx_delay = 10;
  bit spur_done = 1'b0;
  int cnt_a = 0, cnt_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    logic [31:0] s;
    s = (w >> (8 * (3 - b))) & 32'hFF;
    return s[7:0];
  endfunction

  // Tx models: acknowledge each byte tx_delay cycles after its start pulse
  always @(negedge clk) begin
    done_in_a = 1'b0;
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin
        done_in_a = 1'b1;
        done_cyc  = cyc;
      end
    end
    if (tx_start_a) begin
      cnt_a = tx_delay;
      if (spur_done) done_in_a = 1'b1;
    end
  end

  always @(negedge clk) begin
    done_in_b = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) done_in_b = 1'b1;
    end
    if (tx_start_b) cnt_b = 3;
  end

  // Monitors
  always @(negedge clk) begin
    if (tx_start_a) begin
      chk("a_byte_expected", 64'(exp_a.size() != 0), 64'd1);
      if (exp_a.size() != 0) begin
        exp_t e;
        int   lat;
        e   = exp_a.pop_front();
        lat = cyc - (e.from_start ? start_cyc : done_cyc);
        chk("a_byte", 64'(data_a), 64'(e.data));
        chk("a_select", 64'(sel_a), 64'(e.sel));
        chk(e.from_start ? "a_lat_start" : "a_lat_done", 64'(lat), 64'(e.lat));
      end
      bytes_a++;
    end
    if (done_a) dones_a++;
  end

  always @(negedge clk) begin
    if (busy_b) chk("b_select_zero", 64'(sel_b), 64'd0);
    if (tx_start_b) begin
      chk("b_byte_expected", 64'(exp_b.size() != 0), 64'd1);
      if (exp_b.size() != 0) begin
        exp_t e;
        e = exp_b.pop_front();
        chk("b_byte", 64'(data_b), 64'(e.data));
      end
    end
    if (done_b) dones_b++;
  end

  task automatic push_dump_a();
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        exp_t e;
        e.sel        = w;
        e.data       = byte_of(mem_a[w], b);
        e.from_start = (w == 0 && b == 0);
        e.lat        = (w == 0 && b == 0) ? 3 : ((b == 0) ? 4 : 1);
        exp_a.push_back(e);
      end
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", 64'(busy_a), 64'd1);
  endtask

  task automatic dump_a(input bit spur_start, input bit start_on_done);
    int base_bytes, base_dones;
    bit got;
    base_bytes = bytes_a;
    base_dones = dones_a;
    push_dump_a();
    pulse_start_a();
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start_a = spur_start && (i == 25);
      if (done_a) begin
        got = 1'b1;
        break;
      end
    end
    chk("a_done_seen", 64'(got), 64'd1);
    if (start_on_done) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_done", 64'(busy_a), 64'd0);
    repeat (8) @(negedge clk);
    chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
    chk("a_byte_count", 64'(bytes_a - base_bytes), 64'd16);
    chk("a_done_count", 64'(dones_a - base_dones), 64'd1);
    chk("a_idle_select", 64'(sel_a), 64'd0);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end

    // Reset held while start toggles
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_a = i[0];
      start_b = i[0];
      chk("reset_outputs_a", 64'({sel_a, tx_start_a, data_a, busy_a, done_a}), 64'd0);
      chk("reset_outputs_b", 64'({sel_b, tx_start_b, data_b, busy_b, done_b}), 64'd0);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed dump
    mem_a[0] = 32'h11223344;
    mem_a[1] = 32'hA5A5A5A5;
    mem_a[2] = 32'h00000010;
    mem_a[3] = 32'hFFFFFFFF;
    mem_a[4] = 32'hBAADF00D;
    tx_delay = 10;
    dump_a(1'b0, 1'b0);

    // Spurious done in SEND and spurious start mid-dump
    spur_done = 1'b1;
    dump_a(1'b1, 1'b0);
    spur_done = 1'b0;

    // Reset after byte 6
    begin
      int base;
      base = bytes_a;
      push_dump_a();
      pulse_start_a();
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (bytes_a - base >= 6) begin
          got = 1'b1;
          break;
        end
      end
      chk("mid_dump_progress", 64'(got), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      exp_a.delete();
      @(negedge clk);
      chk("mid_reset_outputs", 64'({sel_a, tx_start_a, data_a, busy_a, done_a}), 64'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_reset_idle", 64'({sel_a, tx_start_a, busy_a}), 64'd0);
    end
    mem_a[0] = 32'h01020304;
    mem_a[1] = 32'h80706050;
    dump_a(1'b0, 1'b0);

    // Start in the same cycle as done is dropped
    dump_a(1'b0, 1'b1);

    // Randomized dumps
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 8; w++) mem_a[w] = $urandom;
      tx_delay  = $urandom_range(1, 12);
      spur_done = 1'($urandom_range(0, 1));
      dump_a(1'($urandom_range(0, 1)), 1'b0);
    end
    spur_done = 1'b0;

    // Single-word instance
    mem_b[0] = 32'hDEADBEEF;
    mem_b[1] = 32'h12345678;
    for (int b = 0; b < 4; b++) begin
      exp_t e;
      e.sel        = 0;
      e.data       = byte_of(mem_b[0], b);
      e.from_start = 1'b0;
      e.lat        = 0;
      exp_b.push_back(e);
    end
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_b) begin
        got = 1'b1;
        break;
      end
    end
    chk("b_done_seen", 64'(got), 64'd1);
    repeat (6) @(negedge clk);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    chk("b_done_count", 64'(dones_b), 64'd1);
    chk("b_busy_after_done", 64'(busy_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
